eng_job_sched: RTL and testbench

Job-level scheduler for the erasure-coding engine. Accepts one encode job (stripe count, K, M, beats per stripe) from the control registers and sequences the engine through engine reset, one-time bitmatrix load, input-buffer-fed calculation, and output-buffer drain for every stripe. It sits in the control domain between the register file and the engine, bitmatrix controller and input/output buffers. It owns all their enables for the duration of a job.

---
 rtl/eng_job_sched_pkg.sv | 19 +
 rtl/eng_job_sched_cnt.sv | 34 +++
 rtl/eng_job_sched.sv | 187 ++++++++++++++++++
 tb/tb_eng_job_sched.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eng_job_sched_pkg.sv
// Shared control definitions for the erasure-coding job scheduler:
// FSM state encoding and the fixed phase lengths.
package eng_job_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENG_RST,
    BM_LOAD,
    CALC,
    DRAIN,
    NEXT,
    DONE
  } sched_state_t;

  localparam int ENG_RST_CYCLES   = 2;
  localparam int DRAIN_MIN_CYCLES = 2;
  localparam int PHASE_W          = 2;

endpackage

// File: rtl/eng_job_sched_cnt.sv
// Loadable up-counter with a terminal-count compare against a runtime limit.
// Clear has priority over increment.
module sched_cnt
  import eng_job_sched_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_last);

endmodule

// File: rtl/eng_job_sched.sv
// Job-level scheduler: sequences engine reset, one-time bitmatrix load,
// per-stripe calculation and output drain, and owns all engine/buffer enables.
module eng_job_sched
  import eng_job_sched_pkg::*;
#(
  parameter int K_MAX    = 8,
  parameter int M_MAX    = 4,
  parameter int STRIPE_W = 16,
  parameter int BEAT_W   = 12,
  localparam int KW      = $clog2(K_MAX + 1),
  localparam int MW      = $clog2(M_MAX + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                job_start,
  input  logic                job_abort,
  input  logic [STRIPE_W-1:0] job_num_stripes,
  input  logic [BEAT_W-1:0]   job_beats,
  input  logic [KW-1:0]       job_k,
  input  logic [MW-1:0]       job_m,
  input  logic                inbuff_empty,
  input  logic                outbuff_full,
  input  logic                eng_empty,
  input  logic                bm_load_done,
  output logic                eng_rstn,
  output logic                bm_load_req,
  output logic                cntrl_inbuff_rd_en,
  output logic                cntrl_eng_calc_en,
  output logic                cntrl_outbuff_wr_en,
  output logic                job_busy,
  output logic                job_done,
  output logic                job_err,
  output logic [STRIPE_W-1:0] stripe_idx
);

  localparam logic [KW-1:0]       K_LIMIT    = KW'(K_MAX);
  localparam logic [MW-1:0]       M_LIMIT    = MW'(M_MAX);
  localparam logic [BEAT_W-1:0]   BEAT_ONE   = BEAT_W'(1);
  localparam logic [STRIPE_W-1:0] STRIPE_ONE = STRIPE_W'(1);
  localparam logic [PHASE_W-1:0]  PHASE_ONE  = PHASE_W'(1);
  localparam logic [PHASE_W-1:0]  RST_LAST   = PHASE_W'(ENG_RST_CYCLES - 1);
  localparam logic [PHASE_W-1:0]  DRAIN_LAST = PHASE_W'(DRAIN_MIN_CYCLES - 1);

  sched_state_t          r_state;
  logic [PHASE_W-1:0]    r_phase;
  logic                  r_first;
  logic                  r_abort;
  logic                  r_job_done;
  logic                  r_job_err;
  logic [STRIPE_W-1:0]   r_num_stripes;
  logic [BEAT_W-1:0]     r_beats;

  logic                  w_cfg_ok;
  logic                  w_accept;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_beat_tc;
  logic                  w_stripe_tc;
  logic                  w_stripe_inc;
  logic [BEAT_W-1:0]     w_beat_cnt;
  logic [STRIPE_W-1:0]   w_stripe_idx;

  assign w_cfg_ok = (job_num_stripes != '0) && (job_beats != '0) &&
                    (job_k != '0) && (job_k <= K_LIMIT) &&
                    (job_m != '0) && (job_m <= M_LIMIT);
  assign w_accept = (r_state == IDLE) && job_start && w_cfg_ok;

  // Flow-control strobes follow the buffers combinationally; abort kills them at once.
  assign w_rd = (r_state == CALC)  && !inbuff_empty && !job_abort;
  assign w_wr = (r_state == DRAIN) && !eng_empty && !outbuff_full && !job_abort;
  assign w_stripe_inc = (r_state == NEXT) && !w_stripe_tc && !job_abort;

  sched_cnt #(.W(BEAT_W)) u_beat_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (w_accept || (w_rd && w_beat_tc)),
    .i_inc  (w_rd),
    .i_last (r_beats - BEAT_ONE),
    .o_cnt  (w_beat_cnt),
    .o_tc   (w_beat_tc)
  );

  sched_cnt #(.W(STRIPE_W)) u_stripe_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (w_accept),
    .i_inc  (w_stripe_inc),
    .i_last (r_num_stripes - STRIPE_ONE),
    .o_cnt  (w_stripe_idx),
    .o_tc   (w_stripe_tc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_phase       <= '0;
      r_first       <= 1'b0;
      r_abort       <= 1'b0;
      r_job_done    <= 1'b0;
      r_job_err     <= 1'b0;
      r_num_stripes <= '0;
      r_beats       <= '0;
    end else begin
      r_job_done <= 1'b0;
      r_job_err  <= 1'b0;
      if ((r_state != IDLE) && job_abort) begin
        r_state <= ENG_RST;
        r_phase <= '0;
        r_abort <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (job_start) begin
              if (w_cfg_ok) begin
                r_state       <= ENG_RST;
                r_phase       <= '0;
                r_first       <= 1'b1;
                r_abort       <= 1'b0;
                r_num_stripes <= job_num_stripes;
                r_beats       <= job_beats;
              end else begin
                r_job_err <= 1'b1;
              end
            end
          end
          ENG_RST: begin
            if (r_phase == RST_LAST) begin
              r_phase <= '0;
              if (r_abort) begin
                r_state   <= IDLE;
                r_abort   <= 1'b0;
                r_job_err <= 1'b1;
              end else if (r_first) begin
                r_state <= BM_LOAD;
              end else begin
                r_state <= CALC;
              end
            end else begin
              r_phase <= r_phase + PHASE_ONE;
            end
          end
          BM_LOAD: begin
            if (bm_load_done) begin
              r_first <= 1'b0;
              r_state <= CALC;
            end
          end
          CALC: begin
            if (w_rd && w_beat_tc) begin
              r_state <= DRAIN;
              r_phase <= '0;
            end
          end
          // The first drain cycle never exits, covering the engine result latency.
          DRAIN: begin
            if (eng_empty && (r_phase == DRAIN_LAST)) begin
              r_state <= NEXT;
              r_phase <= '0;
            end else if (r_phase != DRAIN_LAST) begin
              r_phase <= r_phase + PHASE_ONE;
            end
          end
          NEXT: begin
            r_phase <= '0;
            r_state <= w_stripe_tc ? DONE : ENG_RST;
          end
          DONE: begin
            r_state    <= IDLE;
            r_job_done <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign eng_rstn            = (r_state != ENG_RST);
  assign bm_load_req         = (r_state == BM_LOAD);
  assign cntrl_inbuff_rd_en  = w_rd;
  assign cntrl_eng_calc_en   = w_rd;
  assign cntrl_outbuff_wr_en = w_wr;
  assign job_busy            = (r_state != IDLE);
  assign job_done            = r_job_done;
  assign job_err             = r_job_err;
  assign stripe_idx          = w_stripe_idx;

endmodule

// File: tb/tb_eng_job_sched.sv
// Self-checking bench for eng_job_sched: a phase-level reference model checked
// every cycle, plus per-scenario event counts against hand-computed values.
module tb_eng_job_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        job_start = 1'b0;
  logic        job_abort = 1'b0;
  logic [15:0] job_num_stripes = '0;
  logic [11:0] job_beats = '0;
  logic [3:0]  job_k = '0;
  logic [2:0]  job_m = '0;
  logic        inbuff_empty = 1'b0;
  logic        outbuff_full = 1'b0;
  logic        eng_empty = 1'b1;
  logic        bm_load_done;
  logic        eng_rstn, bm_load_req, rd_en, calc_en, wr_en;
  logic        job_busy, job_done, job_err;
  logic [15:0] stripe_idx;

  always #5 clk = ~clk;

  eng_job_sched dut (
    .clk                 (clk),
    .rstn                (rstn),
    .job_start           (job_start),
    .job_abort           (job_abort),
    .job_num_stripes     (job_num_stripes),
    .job_beats           (job_beats),
    .job_k               (job_k),
    .job_m               (job_m),
    .inbuff_empty        (inbuff_empty),
    .outbuff_full        (outbuff_full),
    .eng_empty           (eng_empty),
    .bm_load_done        (bm_load_done),
    .eng_rstn            (eng_rstn),
    .bm_load_req         (bm_load_req),
    .cntrl_inbuff_rd_en  (rd_en),
    .cntrl_eng_calc_en   (calc_en),
    .cntrl_outbuff_wr_en (wr_en),
    .job_busy            (job_busy),
    .job_done            (job_done),
    .job_err             (job_err),
    .stripe_idx          (stripe_idx)
  );

  int passCount = 0;
  int checkCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  // Bitmatrix controller stand-in: reports done on the third cycle of a request.
  initial begin
    int reqAge;
    reqAge = 0;
    bm_load_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bm_load_req) reqAge++;
      else reqAge = 0;
      bm_load_done = (reqAge >= 3);
    end
  end

  // Reference model. Phases: 0 idle, 1 engine reset, 2 bitmatrix load,
  // 3 calculate, 4 drain, 5 next stripe, 6 done.
  int mPh = 0, mRstLeft = 0, mBeatsSeen = 0, mBeats = 0;
  int mStripe = 0, mStripes = 0, mDrainAge = 0;
  bit mFirst = 0, mAbort = 0, mDone = 0, mErr = 0;

  function automatic bit legalCfg(input int ns, input int beats, input int k, input int m);
    return (ns >= 1) && (beats >= 1) && (k >= 1) && (k <= 8) && (m >= 1) && (m <= 4);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mPh <= 0; mRstLeft <= 0; mBeatsSeen <= 0; mBeats <= 0;
      mStripe <= 0; mStripes <= 0; mDrainAge <= 0;
      mFirst <= 0; mAbort <= 0; mDone <= 0; mErr <= 0;
    end else begin
      mDone <= 0;
      mErr <= 0;
      if (mPh != 0 && job_abort) begin
        mPh <= 1; mRstLeft <= 2; mAbort <= 1;
      end else begin
        case (mPh)
          0: if (job_start) begin
               if (legalCfg(int'(job_num_stripes), int'(job_beats), int'(job_k), int'(job_m))) begin
                 mPh <= 1; mRstLeft <= 2; mFirst <= 1; mAbort <= 0;
                 mBeats <= int'(job_beats); mStripes <= int'(job_num_stripes);
                 mBeatsSeen <= 0; mStripe <= 0;
               end else mErr <= 1;
             end
          1: if (mRstLeft == 1) begin
               if (mAbort) begin mPh <= 0; mErr <= 1; mAbort <= 0; end
               else mPh <= mFirst ? 2 : 3;
             end else mRstLeft <= mRstLeft - 1;
          2: if (bm_load_done) begin mFirst <= 0; mPh <= 3; end
          3: if (!inbuff_empty) begin
               if (mBeatsSeen + 1 == mBeats) begin mBeatsSeen <= 0; mPh <= 4; mDrainAge <= 0; end
               else mBeatsSeen <= mBeatsSeen + 1;
             end
          4: begin
               mDrainAge <= mDrainAge + 1;
               if (eng_empty && mDrainAge >= 1) mPh <= 5;
             end
          5: if (mStripe + 1 == mStripes) mPh <= 6;
             else begin mStripe <= mStripe + 1; mPh <= 1; mRstLeft <= 2; end
          default: begin mPh <= 0; mDone <= 1; end
        endcase
      end
    end
  end

  // Per-scenario event counters.
  int rdCount, wrCount, rstLowCycles, bmReqRises, doneCount, errCount, busyCycles;
  int rdWhileEmpty, wrWhileFull, rdDuringAbort, doneWhileBusy, maxStripe;
  bit prevReq = 0;
  logic [7:0] actFlags, expFlags;
  bit expRd, expWr;

  task automatic clearStats();
    rdCount = 0; wrCount = 0; rstLowCycles = 0; bmReqRises = 0; doneCount = 0;
    errCount = 0; busyCycles = 0; rdWhileEmpty = 0; wrWhileFull = 0;
    rdDuringAbort = 0; doneWhileBusy = 0; maxStripe = 0;
  endtask

  // Every cycle: compare all outputs to the model, then accumulate event counts.
  always @(negedge clk) begin
    expRd = (mPh == 3) && !inbuff_empty && !job_abort;
    expWr = (mPh == 4) && !eng_empty && !outbuff_full && !job_abort;
    expFlags = {mPh != 1, mPh == 2, expRd, expRd, expWr, mPh != 0, mDone, mErr};
    actFlags = {eng_rstn, bm_load_req, rd_en, calc_en, wr_en, job_busy, job_done, job_err};
    checkOutput("cycle_flags", {24'b0, actFlags}, {24'b0, expFlags});
    checkOutput("cycle_stripe", {16'b0, stripe_idx}, mStripe);
    if (rd_en) rdCount++;
    if (wr_en) wrCount++;
    if (!eng_rstn) rstLowCycles++;
    if (bm_load_req && !prevReq) bmReqRises++;
    prevReq = bm_load_req;
    if (job_done) doneCount++;
    if (job_err) errCount++;
    if (job_busy) busyCycles++;
    if (rd_en && inbuff_empty) rdWhileEmpty++;
    if (wr_en && outbuff_full) wrWhileFull++;
    if (rd_en && job_abort) rdDuringAbort++;
    if (job_done && job_busy) doneWhileBusy++;
    if (int'(stripe_idx) > maxStripe) maxStripe = int'(stripe_idx);
  end

  task automatic applyStimulus(input int ns, input int beats, input int k, input int m);
    @(posedge clk);
    #1;
    job_num_stripes = 16'(ns);
    job_beats = 12'(beats);
    job_k = 4'(k);
    job_m = 3'(m);
    job_start = 1'b1;
  endtask

  // Mode 0 static, 1 input toggling, 2 output backpressure, 3 abort at cycle 8.
  task automatic waitJob(input int mode, input int maxCycles);
    bit finished;
    finished = 0;
    for (int cyc = 1; cyc <= maxCycles && !finished; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) job_start = 1'b0;
      case (mode)
        1: inbuff_empty = (cyc % 2 == 1);
        2: begin outbuff_full = (cyc <= 17); eng_empty = (cyc > 20); end
        3: job_abort = (cyc == 8);
        default: ;
      endcase
      if (cyc > 1 && !job_busy) finished = 1;
    end
    if (!finished) checkOutput("job_timeout", {31'b0, job_busy}, 32'd0);
    inbuff_empty = 1'b0;
    outbuff_full = 1'b0;
    eng_empty = 1'b1;
    job_abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    clearStats();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_flags", {24'b0, eng_rstn, bm_load_req, rd_en, calc_en, wr_en,
                                job_busy, job_done, job_err}, 32'h80);
    checkOutput("reset_stripe", {16'b0, stripe_idx}, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;

    $display("[TB] basic job: 1 stripe, 4 beats");
    clearStats();
    applyStimulus(1, 4, 4, 2);
    waitJob(0, 100);
    checkOutput("basic_reads", rdCount, 4);
    checkOutput("basic_rst_low", rstLowCycles, 2);
    checkOutput("basic_busy_cycles", busyCycles, 13);
    checkOutput("basic_done", doneCount, 1);
    checkOutput("basic_done_while_busy", doneWhileBusy, 0);

    $display("[TB] three stripes, 2 beats");
    clearStats();
    applyStimulus(3, 2, 8, 4);
    waitJob(0, 200);
    checkOutput("multi_bm_req", bmReqRises, 1);
    checkOutput("multi_rst_low", rstLowCycles, 6);
    checkOutput("multi_reads", rdCount, 6);
    checkOutput("multi_max_stripe", maxStripe, 2);
    checkOutput("multi_busy_cycles", busyCycles, 25);
    checkOutput("multi_done", doneCount, 1);

    $display("[TB] input stall, 5 beats");
    clearStats();
    applyStimulus(1, 5, 1, 1);
    waitJob(1, 200);
    checkOutput("stall_reads", rdCount, 5);
    checkOutput("stall_rd_while_empty", rdWhileEmpty, 0);
    checkOutput("stall_busy_cycles", busyCycles, 18);

    $display("[TB] output backpressure");
    clearStats();
    outbuff_full = 1'b1;
    eng_empty = 1'b0;
    applyStimulus(1, 2, 2, 2);
    waitJob(2, 200);
    checkOutput("bp_writes", wrCount, 3);
    checkOutput("bp_wr_while_full", wrWhileFull, 0);
    checkOutput("bp_busy_cycles", busyCycles, 23);

    $display("[TB] illegal configurations");
    clearStats();
    applyStimulus(1, 4, 0, 2);
    waitJob(0, 20);
    applyStimulus(1, 4, 4, 5);
    waitJob(0, 20);
    applyStimulus(0, 4, 4, 2);
    waitJob(0, 20);
    checkOutput("illegal_errs", errCount, 3);
    checkOutput("illegal_busy", busyCycles, 0);
    checkOutput("illegal_enables", rdCount + wrCount + rstLowCycles + bmReqRises, 0);

    $display("[TB] abort mid-calc");
    clearStats();
    applyStimulus(1, 8, 4, 2);
    waitJob(3, 100);
    checkOutput("abort_reads", rdCount, 2);
    checkOutput("abort_rd_same_cycle", rdDuringAbort, 0);
    checkOutput("abort_rst_low", rstLowCycles, 4);
    checkOutput("abort_err", errCount, 1);
    checkOutput("abort_done", doneCount, 0);
    checkOutput("abort_busy_cycles", busyCycles, 10);
    clearStats();
    applyStimulus(1, 4, 4, 2);
    waitJob(0, 100);
    checkOutput("post_abort_reads", rdCount, 4);
    checkOutput("post_abort_done", doneCount, 1);
    checkOutput("post_abort_err", errCount, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
